jt51_chacc: RTL and testbench
=============================

Name: jt51_chacc

Overview:
- Output accumulator directly downstream of the pipelined operator.
- Consumes one signed operator sample per clock in slot order, decides per slot whether the operator is a carrier for its channel's connection algorithm, and sums carriers into left/right frame accumulators.
- Once per 32-slot frame, saturates the sums to the output width and presents a stereo sample with a one-cycle strobe; feeds the DAC/filter stage.

Parameters:
- OPW, 14, width of signed operator sample input.
- OUTW, 16, width of signed output samples; must satisfy OUTW <= OPW+5.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- zero  input  1  high on the cycle whose op_out belongs to slot 0 of a frame.
- op_out  input  OPW  signed operator output for the current slot.
- con  input  3  connection algorithm of the current slot's channel.
- rl  input  2  channel output enables: bit1 = left, bit0 = right.
- left  output  OUTW  signed saturated left sample.
- right  output  OUTW  signed saturated right sample.
- sample  output  1  one-cycle strobe; left/right were updated this cycle.
- clip  output  1  high with sample if either channel saturated in that frame; held until next sample.

Behaviour:
- Clock clk; reset rst is synchronous, active-high. Reset values:
  - left=0, right=0, sample=0, clip=0.
  - Slot counter cnt=0; accumulators accl=accr=0; frame-valid flag fv=0.
- Slot index: slot = zero ? 0 : cnt.
  - cnt update: zero ? 1 : cnt+1, 5-bit wrap 31->0.
  - Slot groups: 0-7 M1, 8-15 M2, 16-23 C1, 24-31 C2. Channel = slot[2:0] (informational only).
- Carrier decode, combinational on slot and con:
  - C2 always a carrier.
  - C1 a carrier if con >= 4.
  - M2 a carrier if con >= 5.
  - M1 a carrier only if con == 7.
- Contribution:
  - cl = (carrier & rl[1]) ? sign-extended op_out : 0.
  - cr = (carrier & rl[0]) ? sign-extended op_out : 0.
  - Accumulators are OPW+5 bits signed. 32 terms cannot overflow; no internal wrap.
- Non-zero cycle: accl <= accl+cl, accr <= accr+cr.
- Zero cycle:
  - Frame end test: a frame is complete iff fv==1 and cnt==0, i.e. exactly 32 slots elapsed since the previous zero.
  - If complete, next cycle:
    - left <= sat(accl), right <= sat(accr).
    - sample <= 1.
    - clip <= (either sat() clipped).
  - Otherwise: sample stays 0; left/right/clip hold.
  - In both cases: accl <= cl, accr <= cr (restart with slot 0), and fv <= 1.
- sat(x): clamp to [-2^(OUTW-1), 2^(OUTW-1)-1]; no shifting or scaling.
- Latency: the slot-31 operator value reaches left/right 2 cycles after it is presented (accumulate, then latch on the following zero edge).
- sample is high exactly one cycle per complete frame and 0 on all other cycles.
- Boundary cases:
  - First frame after reset is discarded (fv=0).
  - zero arriving early or late (cnt!=0) is a resync: no sample, accumulation restarts at slot 0.
  - Missing zero: cnt wraps and accumulation continues; the next zero finds cnt!=0 unless exactly 32k slots passed. For k>1 it emits the multi-frame sum, which is intended behaviour for a stalled sync.
  - rst asserted mid-frame: all state returns to reset values on that edge; the zero arriving in the same cycle as rst is ignored.
- con and rl are sampled on the same cycle as op_out; they must be slot-aligned by the upstream stage.

Test Plan:
- Reset, then zero every 32 cycles; op_out=100 on all slots, con=7, rl=2'b11 -> first zero gives no sample; second zero gives left=right=3200, sample one cycle, clip=0.
- con=0, rl=2'b10, op_out=500 on C2 slots, 999 elsewhere -> left=4000, right=0.
- Per-slot con: slot 16 (C1, con=4) op_out=-300, slot 8 (M2, con=4) op_out=700, slot 24 op_out=50, rest 0, rl=11 -> left=right=-250.
- op_out=8191 all slots, con=7, rl=11 -> accumulator 262112; left=right=32767, clip=1; next frame all -8192 -> -32768, clip=1.
- zero pulsed 20 cycles after previous zero -> no sample, outputs hold; a following zero 32 cycles later -> sample reflecting only those 32 slots.
- rst for one cycle mid-frame, including a cycle with zero=1 -> left=right=0, sample=0, clip=0; first sample appears only on the second zero after reset.

Source files
------------

// File: rtl/jt51_chacc_if.sv
// Operator-to-accumulator bus for jt51_chacc.
// The master drives per-slot operator data; the slave returns the
// saturated stereo frame sample with its strobe and clip flag.
interface jt51_chacc_if #(
    parameter int OPW  = 14,
    parameter int OUTW = 16
);
    // Slot-aligned operator stream
    logic                   zero;
    logic signed [OPW-1:0]  op_out;
    logic [2:0]             con;
    logic [1:0]             rl;

    // Frame-rate stereo result
    logic signed [OUTW-1:0] left;
    logic signed [OUTW-1:0] right;
    logic                   sample;
    logic                   clip;

    // Upstream operator pipeline / test driver side
    modport master (
        output zero, op_out, con, rl,
        input  left, right, sample, clip
    );

    // Accumulator side
    modport slave (
        input  zero, op_out, con, rl,
        output left, right, sample, clip
    );
endinterface

// File: rtl/jt51_chacc.sv
// Channel output accumulator. Sums carrier operators of each 32-slot frame
// into left/right accumulators and, on the zero marker that closes a full
// frame, latches saturated stereo samples with a one-cycle strobe.
module jt51_chacc #(
    parameter int OPW  = 14,
    parameter int OUTW = 16
) (
    input  logic         clk,
    input  logic         rst,
    jt51_chacc_if.slave  bus
);
    // Accumulator width: 32 full-scale terms need 5 extra bits.
    localparam int AW = OPW + 5;

    // Output clamp limits expressed at accumulator width.
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};

    // Slot groups (slot[4:3])
    typedef enum logic [1:0] {
        GRP_M1 = 2'd0,
        GRP_M2 = 2'd1,
        GRP_C1 = 2'd2,
        GRP_C2 = 2'd3
    } grp_e;

    // State
    logic [4:0]             cnt_q,    cnt_d;
    logic signed [AW-1:0]   accl_q,   accl_d;
    logic signed [AW-1:0]   accr_q,   accr_d;
    logic                   fv_q,     fv_d;
    logic signed [OUTW-1:0] left_q,   left_d;
    logic signed [OUTW-1:0] right_q,  right_d;
    logic                   sample_q, sample_d;
    logic                   clip_q,   clip_d;

    // Per-slot decode
    grp_e                   grp;
    logic                   carrier;
    logic signed [AW-1:0]   op_ext;
    logic signed [AW-1:0]   cl;
    logic signed [AW-1:0]   cr;
    logic                   frame_done;

    // Clamp to the signed output range; no scaling.
    function automatic logic signed [OUTW-1:0] sat_val(input logic signed [AW-1:0] x);
        if (x > SAT_MAX)      sat_val = SAT_MAX[OUTW-1:0];
        else if (x < SAT_MIN) sat_val = SAT_MIN[OUTW-1:0];
        else                  sat_val = x[OUTW-1:0];
    endfunction

    // True when x lies outside the output range.
    function automatic logic sat_hit(input logic signed [AW-1:0] x);
        sat_hit = (x > SAT_MAX) || (x < SAT_MIN);
    endfunction

    // Carrier decode and per-channel contribution for the current slot
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grp     = bus.zero ? GRP_M1 : grp_e'(cnt_q[4:3]);
        carrier = 1'b0;
        case (grp)
            GRP_M1:  carrier = (bus.con == 3'd7);
            GRP_M2:  carrier = (bus.con >= 3'd5);
            GRP_C1:  carrier = (bus.con >= 3'd4);
            GRP_C2:  carrier = 1'b1;
            default: carrier = 1'b0;
        endcase
        op_ext = {{5{bus.op_out[OPW-1]}}, bus.op_out};
        cl     = (carrier && bus.rl[1]) ? op_ext : '0;
        cr     = (carrier && bus.rl[0]) ? op_ext : '0;
    end

    // Next-state: accumulate, or close the frame on zero
    always_comb begin
        cnt_d      = bus.zero ? 5'd1 : cnt_q + 5'd1;
        frame_done = bus.zero && fv_q && (cnt_q == 5'd0);
        accl_d     = accl_q + cl;
        accr_d     = accr_q + cr;
        fv_d       = fv_q;
        left_d     = left_q;
        right_d    = right_q;
        clip_d     = clip_q;
        sample_d   = 1'b0;
        if (bus.zero) begin
            // Slot 0 restarts the sums whether or not the frame was whole.
            accl_d = cl;
            accr_d = cr;
            fv_d   = 1'b1;
            if (frame_done) begin
                left_d   = sat_val(accl_q);
                right_d  = sat_val(accr_q);
                clip_d   = sat_hit(accl_q) || sat_hit(accr_q);
                sample_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset; reset wins over zero
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples its _d value from before this edge.
        if (rst) begin
            cnt_q    <= '0;
            accl_q   <= '0;
            accr_q   <= '0;
            fv_q     <= 1'b0;
            left_q   <= '0;
            right_q  <= '0;
            sample_q <= 1'b0;
            clip_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            accl_q   <= accl_d;
            accr_q   <= accr_d;
            fv_q     <= fv_d;
            left_q   <= left_d;
            right_q  <= right_d;
            sample_q <= sample_d;
            clip_q   <= clip_d;
        end
    end

    assign bus.left   = left_q;
    assign bus.right  = right_q;
    assign bus.sample = sample_q;
    assign bus.clip   = clip_q;

endmodule

// File: tb/tb_jt51_chacc.sv
// Self-checking bench for jt51_chacc: a behavioural frame model pushes the
// expected stereo sample when a frame-closing zero is driven; a monitor pops
// and compares whenever the DUT strobes sample.
module tb_jt51_chacc;
    localparam int OPW  = 14;
    localparam int OUTW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jt51_chacc_if #(.OPW(OPW), .OUTW(OUTW)) bus ();

    jt51_chacc #(.OPW(OPW), .OUTW(OUTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int l;
        int r;
        int clip;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_samples = 0;
    int   n_pushed  = 0;
    int   cyc = 0;

    // Frame model state
    int   m_sum_l = 0;
    int   m_sum_r = 0;
    int   m_len   = 0;
    bit   m_valid = 1'b0;
    int   m_last_l = 0;
    int   m_last_r = 0;
    int   m_last_c = 0;

    // Stimulus pattern for one drive_frame call
    int   pat_op  [64];
    int   pat_con [64];
    int   pat_rl  [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_carrier(input int slot, input int c);
        if (slot < 8)       return c == 7;
        else if (slot < 16) return c == 5 || c == 6 || c == 7;
        else if (slot < 24) return c == 4 || c == 5 || c == 6 || c == 7;
        else                return 1'b1;
    endfunction

    function automatic int clamp(input int x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Drive one slot and advance the model
    task automatic drive_slot(input bit z, input int op, input int c, input int r);
        int slot;
        int contrib;
        exp_t e;
        @(posedge clk);
        #1;
        bus.zero   = z;
        bus.op_out = OPW'(op);
        bus.con    = 3'(c);
        bus.rl     = 2'(r);
        slot    = z ? 0 : (m_len % 32);
        contrib = is_carrier(slot, c) ? op : 0;
        if (z) begin
            if (m_valid && m_len > 0 && (m_len % 32) == 0) begin
                e.l    = clamp(m_sum_l);
                e.r    = clamp(m_sum_r);
                e.clip = (e.l != m_sum_l || e.r != m_sum_r) ? 1 : 0;
                e.cyc  = cyc;
                exp_q.push_back(e);
                n_pushed++;
                m_last_l = e.l;
                m_last_r = e.r;
                m_last_c = e.clip;
            end
            m_sum_l = r[1] ? contrib : 0;
            m_sum_r = r[0] ? contrib : 0;
            m_len   = 1;
            m_valid = 1'b1;
        end else begin
            m_sum_l += r[1] ? contrib : 0;
            m_sum_r += r[0] ? contrib : 0;
            m_len++;
        end
    endtask

    task automatic drive_frame(input int n);
        for (int i = 0; i < n; i++)
            drive_slot(i == 0, pat_op[i], pat_con[i], pat_rl[i]);
    endtask

    task automatic fill(input int op, input int c, input int r);
        for (int i = 0; i < 64; i++) begin
            pat_op[i]  = op;
            pat_con[i] = c;
            pat_rl[i]  = r;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            pat_op[i]  = int'($urandom_range(0, 16383)) - 8192;
            pat_con[i] = int'($urandom_range(0, 7));
            pat_rl[i]  = int'($urandom_range(0, 3));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_left"},   int'($signed(bus.left)),  0);
        check({tag, "_right"},  int'($signed(bus.right)), 0);
        check({tag, "_sample"}, int'(bus.sample),         0);
        check({tag, "_clip"},   int'(bus.clip),           0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.sample) begin
            n_samples++;
            check("sample_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("left",           int'($signed(bus.left)),  e.l);
                check("right",          int'($signed(bus.right)), e.r);
                check("clip",           int'(bus.clip),           e.clip);
                check("sample_latency", cyc,                      e.cyc + 1);
            end
        end
    end

    initial begin
        int n_before;
        bus.zero   = 1'b0;
        bus.op_out = '0;
        bus.con    = '0;
        bus.rl     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All carriers, 100 per slot: first zero discarded, then 3200
        fill(100, 7, 3);
        drive_frame(32);

        // con=0, left only: 8 C2 slots of 500 -> 4000 / 0
        fill(999, 0, 2);
        for (int i = 24; i < 32; i++) pat_op[i] = 500;
        drive_frame(32);

        // Per-slot con: C1 with con=4 counts, M2 with con=4 does not
        fill(0, 0, 3);
        pat_op[16] = -300; pat_con[16] = 4;
        pat_op[8]  = 700;  pat_con[8]  = 4;
        pat_op[24] = 50;
        drive_frame(32);

        // Positive and negative full-scale saturation
        fill(8191, 7, 3);
        drive_frame(32);
        fill(-8192, 7, 3);
        drive_frame(32);

        // Early zero after 20 slots: resync, outputs hold
        fill(1234, 7, 3);
        drive_frame(20);
        n_before = n_samples;
        for (int i = 0; i < 32; i++) begin
            pat_op[i]  = i * 10 - 100;
            pat_con[i] = 7;
            pat_rl[i]  = 3;
        end
        drive_frame(32);
        check("resync_no_sample", n_samples, n_before);
        check("resync_hold_left",  int'($signed(bus.left)),  m_last_l);
        check("resync_hold_right", int'($signed(bus.right)), m_last_r);
        check("resync_hold_clip",  int'(bus.clip),           m_last_c);

        // Next zero samples the resynced frame, then reset mid-frame
        fill_random();
        drive_frame(10);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.zero   = 1'b1;
        bus.op_out = OPW'(4000);
        m_valid = 1'b0;
        m_len   = 0;
        m_sum_l = 0;
        m_sum_r = 0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.zero = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");

        // Two random frames after reset: only the second zero samples
        n_before = n_samples;
        fill_random();
        drive_frame(32);
        check("post_reset_first_zero", n_samples, n_before);
        fill_random();
        drive_frame(32);

        // Missing zero: 64 slots emits the two-frame sum
        fill_random();
        drive_frame(64);

        // Closing zero
        drive_slot(1'b1, 0, 0, 0);
        drive_slot(1'b0, 0, 0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pending_expected", exp_q.size(), 0);
        check("sample_count",     n_samples,    n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
